// File: rtl/boot_loader_pkg.sv
// Shared definitions for the flash-to-RAM boot copier: FSM encodings,
// bus widths and the default timing constants.
package boot_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_ISSUE       = 3'd1,
    ST_WAIT_FLASH  = 3'd2,
    ST_WRITE_SETUP = 3'd3,
    ST_WRITE_HOLD  = 3'd4,
    ST_NEXT        = 3'd5,
    ST_DONE        = 3'd6
  } state_e;

  localparam int FLASH_AW = 22;
  localparam int RAM_AW   = 18;
  localparam int DATA_W   = 16;
  localparam int WAIT_W   = 24;
  localparam int HOLD_W   = 4;

  // 12582920 cycles of flash access latency, 2 cycles of RAM write strobe.
  localparam logic [WAIT_W-1:0] DEF_FLASH_WAIT    = 24'd12582920;
  localparam logic [HOLD_W-1:0] DEF_RAM_WE_CYCLES = 4'd2;

endpackage

// File: rtl/down_counter.sv
// Loadable down-counter with a zero flag; it saturates at zero so an
// idle enable never wraps it around.
module down_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q;

  // Load has priority over counting; counting stops at zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/boot_loader.sv
// Copies WORD_COUNT 16-bit words from a toggle-requested flash port into
// an asynchronous SRAM with an active-low, multi-cycle write strobe.
//
// state        | meaning
// -------------+-----------------------------------------------------
// ST_IDLE      | waiting for start after reset
// ST_ISSUE     | present flash address, toggle read request
// ST_WAIT_FLASH| count out flash latency, then capture data
// ST_WRITE_SETUP| address/data settled, drop ram_we
// ST_WRITE_HOLD| hold ram_we low, then release and count the word
// ST_NEXT      | advance to the next word or finish
// ST_DONE      | copy complete, waiting for a new start
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int unsigned         WORD_COUNT    = 1024,
  parameter logic [FLASH_AW-1:0] FLASH_BASE    = 22'h000000,
  parameter logic [RAM_AW-1:0]   RAM_BASE      = 18'h00000,
  parameter logic [WAIT_W-1:0]   FLASH_WAIT    = DEF_FLASH_WAIT,
  parameter logic [HOLD_W-1:0]   RAM_WE_CYCLES = DEF_RAM_WE_CYCLES
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  output logic [FLASH_AW-1:0] flash_rd_addr_o,
  output logic                flash_rd_ctrl_o,
  input  logic [DATA_W-1:0]   flash_rd_data_i,
  output logic [RAM_AW-1:0]   ram_addr_o,
  output logic [DATA_W-1:0]   ram_data_o,
  output logic                ram_we_o,
  output logic                ram_oe_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [15:0]         words_done_o
);

  localparam logic [15:0] LAST_IDX = 16'(WORD_COUNT - 1);
  // Timers expire on the cycle they read zero, so loading N-1 puts the
  // flash sample exactly FLASH_WAIT edges after the toggle edge and keeps
  // ram_we low for exactly RAM_WE_CYCLES cycles.
  localparam logic [WAIT_W-1:0] WAIT_LOAD = FLASH_WAIT - WAIT_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = RAM_WE_CYCLES - HOLD_W'(1);

  state_e              state_q;
  logic [15:0]         idx_q;
  logic [FLASH_AW-1:0] flash_rd_addr_q;
  logic                flash_rd_ctrl_q;
  logic [RAM_AW-1:0]   ram_addr_q;
  logic [DATA_W-1:0]   ram_data_q;
  logic                ram_we_q;
  logic                busy_q;
  logic                done_q;
  logic [15:0]         words_done_q;
  logic                wait_zero;
  logic                hold_zero;

  down_counter #(.WIDTH(WAIT_W)) u_wait_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (state_q == ST_ISSUE),
    .load_val_i (WAIT_LOAD),
    .en_i       (state_q == ST_WAIT_FLASH),
    .zero_o     (wait_zero)
  );

  down_counter #(.WIDTH(HOLD_W)) u_hold_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (state_q == ST_WRITE_SETUP),
    .load_val_i (HOLD_LOAD),
    .en_i       (state_q == ST_WRITE_HOLD),
    .zero_o     (hold_zero)
  );

  // Copy sequencer; all bus outputs are registered here.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= ST_IDLE;
      idx_q           <= '0;
      flash_rd_addr_q <= FLASH_BASE;
      flash_rd_ctrl_q <= 1'b0;
      ram_addr_q      <= RAM_BASE;
      ram_data_q      <= '0;
      ram_we_q        <= 1'b1;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      words_done_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            idx_q        <= '0;
            words_done_q <= '0;
            done_q       <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          flash_rd_addr_q <= FLASH_BASE + {6'd0, idx_q};
          flash_rd_ctrl_q <= ~flash_rd_ctrl_q;
          state_q         <= ST_WAIT_FLASH;
        end
        ST_WAIT_FLASH: begin
          if (wait_zero) begin
            ram_data_q <= flash_rd_data_i;
            ram_addr_q <= RAM_BASE + {2'd0, idx_q};
            state_q    <= ST_WRITE_SETUP;
          end
        end
        ST_WRITE_SETUP: begin
          ram_we_q <= 1'b0;
          state_q  <= ST_WRITE_HOLD;
        end
        ST_WRITE_HOLD: begin
          if (hold_zero) begin
            ram_we_q     <= 1'b1;
            words_done_q <= words_done_q + 16'd1;
            state_q      <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (idx_q == LAST_IDX) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            idx_q   <= idx_q + 16'd1;
            state_q <= ST_ISSUE;
          end
        end
        default: begin
          ram_we_q <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign flash_rd_addr_o = flash_rd_addr_q;
  assign flash_rd_ctrl_o = flash_rd_ctrl_q;
  assign ram_addr_o      = ram_addr_q;
  assign ram_data_o      = ram_data_q;
  assign ram_we_o        = ram_we_q;
  assign ram_oe_o        = 1'b1;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign words_done_o    = words_done_q;

endmodule

// File: doc/boot_loader.md
BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 Parameter WORD_COUNT, default 1024: number of 16-bit words copied per run; legal range 1..65535.
REQ-002 Parameter FLASH_BASE, default 22'h000000: first flash word address.
REQ-003 Parameter RAM_BASE, default 18'h00000: first RAM word address.
REQ-004 Parameter FLASH_WAIT, default 24'd12582920: clk cycles from toggling the flash read request to sampling flash data; legal range 1..2^24-1.
REQ-005 Parameter RAM_WE_CYCLES, default 2: cycles ram_we is held low per write; legal range 1..15.
REQ-006 clk  in  1  single system clock; all logic on posedge clk.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 start  in  1  one-cycle pulse that begins a copy run; honoured only in IDLE or DONE.
REQ-009 flash_rd_addr  out  22  word address [22:1] presented to the flash controller.
REQ-010 flash_rd_ctrl  out  1  toggle-type read request; each level change requests one read.
REQ-011 flash_rd_data  in  16  word returned by the flash controller.
REQ-012 ram_addr  out  18  RAM word address.
REQ-013 ram_data  out  16  RAM write data.
REQ-014 ram_we  out  1  RAM write enable, active-low.
REQ-015 ram_oe  out  1  RAM output enable, active-low; held high by this block.
REQ-016 busy  out  1  high from the cycle after an accepted start until DONE is entered.
REQ-017 done  out  1  high in DONE; cleared by a new start or rst.
REQ-018 words_done  out  16  count of words written to RAM in the current run.

Function
REQ-019 States: IDLE, ISSUE, WAIT_FLASH, WRITE_SETUP, WRITE_HOLD, NEXT, DONE.
REQ-020 IDLE/DONE + start: idx<=0, words_done<=0, done<=0, busy<=1, go to ISSUE.
REQ-021 ISSUE: flash_rd_addr<=FLASH_BASE+idx, invert flash_rd_ctrl, load wait counter with FLASH_WAIT, go to WAIT_FLASH; exactly one toggle per word.
REQ-022 WAIT_FLASH: decrement counter each cycle; on the cycle it reaches 0, register flash_rd_data into ram_data, ram_addr<=RAM_BASE+idx, go to WRITE_SETUP; sampling latency exactly FLASH_WAIT cycles after the toggle edge.
REQ-023 flash_rd_addr SHALL stay constant from ISSUE until the next ISSUE.
REQ-024 WRITE_SETUP: ram_we<=0, load hold counter with RAM_WE_CYCLES, go to WRITE_HOLD.
REQ-025 WRITE_HOLD: ram_we stays 0 for exactly RAM_WE_CYCLES cycles, then ram_we<=1, words_done<=words_done+1, go to NEXT; ram_addr/ram_data stable one cycle before, during and one cycle after ram_we low.
REQ-026 NEXT: if idx==WORD_COUNT-1 go to DONE (busy<=0, done<=1), else idx<=idx+1 and go to ISSUE.
REQ-027 start outside IDLE/DONE SHALL be ignored.
REQ-028 Address arithmetic wraps modulo 2^22 (flash) and 2^18 (RAM); no overflow flag.
REQ-029 Unreachable state encodings SHALL return to IDLE with ram_we=1 next cycle.

Reset
REQ-030 rst (sampled at posedge clk) SHALL force IDLE, flash_rd_ctrl=0, flash_rd_addr=FLASH_BASE, ram_we=1, ram_oe=1, ram_addr=RAM_BASE, ram_data=0, busy=0, done=0, words_done=0, counters=0.
REQ-031 rst mid-run SHALL abort immediately, deasserting ram_we in the same edge; the partial copy is not resumed.
REQ-032 rst and start in the same cycle: rst wins; start is dropped.

Structure
REQ-033 State encodings and the default FLASH_WAIT/RAM_WE_CYCLES constants SHALL live in a shared package used by the flash and RAM control blocks.
REQ-034 One sub-module, down_counter (load, enable, zero flag, parameter width), SHALL serve both the flash wait and the RAM hold timers.

Verification (FLASH_WAIT=4, RAM_WE_CYCLES=2, WORD_COUNT=3, flash model returns 16'hA000+addr)
REQ-035 rst then start pulse -> three toggles of flash_rd_ctrl with flash_rd_addr 0,1,2; RAM receives A000,A001,A002 at addresses 0,1,2; done=1, words_done=3.
REQ-036 Timing: ram_data equals the flash model value 4 cycles after each toggle; ram_we low exactly 2 cycles per word.
REQ-037 start during WAIT_FLASH -> ignored; exactly 3 writes total.
REQ-038 rst asserted in WRITE_HOLD of word 1 -> next edge ram_we=1, busy=0, words_done=0, no further toggles.
REQ-039 FLASH_BASE=22'h3FFFFF, WORD_COUNT=2 -> flash_rd_addr 3FFFFF then 000000.
REQ-040 start in DONE -> done cleared, second full run repeats REQ-035 results.
